// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: register codes, stack opcodes and
//                the state encoding of the PUSH/POP sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Register codes carried on reg_sel
  localparam logic [2:0] REG_R0 = 3'd1;
  localparam logic [2:0] REG_BP = 3'd2;
  localparam logic [2:0] REG_SP = 3'd3;
  localparam logic [2:0] REG_R1 = 3'd4;

  // Stack opcodes
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // One-hot register select positions, shared by decoder and its users
  localparam int SEL_R0 = 0;
  localparam int SEL_BP = 1;
  localparam int SEL_R1 = 2;

  // PUSH/POP sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_ADDR = 3'd2,
    ST_XFER = 3'd3,
    ST_INC  = 3'd4,
    ST_FIN  = 3'd5,
    ST_FLT  = 3'd6
  } stack_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_sel_decode.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sel_decode
//  Description : Decodes a 3-bit register code into a one-hot {r1, bp, r0}
//                select plus a valid flag. sp and unused codes are invalid
//                for bus transfers through this path.
//  Ports       : reg_code   - register code (REG_* in cpu_pkg)
//                reg_onehot - one-hot select, bit positions SEL_* in cpu_pkg
//                reg_valid  - 1 when reg_code names r0, bp or r1
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_sel_decode
  import cpu_pkg::*;
(
  input  logic [2:0] reg_code,
  output logic [2:0] reg_onehot,
  output logic       reg_valid
);

  always_comb begin
    reg_onehot = 3'b000;
    reg_valid  = 1'b0;
    case (reg_code)
      REG_R0: begin
        reg_onehot[SEL_R0] = 1'b1;
        reg_valid          = 1'b1;
      end
      REG_BP: begin
        reg_onehot[SEL_BP] = 1'b1;
        reg_valid          = 1'b1;
      end
      REG_R1: begin
        reg_onehot[SEL_R1] = 1'b1;
        reg_valid          = 1'b1;
      end
      default: begin
        reg_onehot = 3'b000;
        reg_valid  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
//  Module      : stack_seq
//  Description : PUSH/POP execute sequencer for the shared 16-bit bus.
//                Stack grows downward; SP points at the last pushed word.
//                PUSH: DEC -> ADDR -> XFER -> FIN  (pre-decrement)
//                POP : ADDR -> XFER -> INC -> FIN  (post-increment)
//                Illegal register, full or empty stack: FLT (done+fault).
//  Ports       : clk, reset (async, active-low)
//                start/op/reg_sel - request, sampled only in IDLE
//                sp_val           - SP contents, checked at acceptance
//                idr_*/edr_*      - register load / drive enables
//                edr_sp, sp_dec, sp_inc, iaddr, iram, eram - datapath strobes
//                busy, done, fault - sequencer status
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_seq
  import cpu_pkg::*;
#(
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] sp_val,
  output logic        idr_0,
  output logic        idr_bp,
  output logic        idr_1,
  output logic        edr_0,
  output logic        edr_bp,
  output logic        edr_1,
  output logic        edr_sp,
  output logic        sp_dec,
  output logic        sp_inc,
  output logic        iaddr,
  output logic        iram,
  output logic        eram,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  stack_state_t state_q, state_d;
  logic         op_q, op_d;
  logic [2:0]   sel_q, sel_d;

  logic [2:0]   idr_q, idr_d;
  logic [2:0]   edr_q, edr_d;
  logic         edr_sp_q, edr_sp_d;
  logic         sp_dec_q, sp_dec_d;
  logic         sp_inc_q, sp_inc_d;
  logic         iaddr_q, iaddr_d;
  logic         iram_q, iram_d;
  logic         eram_q, eram_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         fault_q, fault_d;

  logic [2:0]   dec_onehot;
  logic         dec_valid;

  reg_sel_decode u_reg_sel_decode (
    .reg_code   (reg_sel),
    .reg_onehot (dec_onehot),
    .reg_valid  (dec_valid)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          sel_d = dec_onehot;
          if (!dec_valid)
            state_d = ST_FLT;
          else if ((op == OP_PUSH) && (sp_val == STACK_LIMIT))
            state_d = ST_FLT;
          else if ((op == OP_POP) && (sp_val == STACK_TOP))
            state_d = ST_FLT;
          else
            state_d = (op == OP_PUSH) ? ST_DEC : ST_ADDR;
        end
      end
      ST_DEC:  state_d = ST_ADDR;
      ST_ADDR: state_d = ST_XFER;
      ST_XFER: state_d = (op_q == OP_PUSH) ? ST_FIN : ST_INC;
      ST_INC:  state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      ST_FLT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so that every strobe is a
  // flop output aligned with the state it belongs to.
  always_comb begin
    idr_d    = 3'b000;
    edr_d    = 3'b000;
    edr_sp_d = 1'b0;
    sp_dec_d = 1'b0;
    sp_inc_d = 1'b0;
    iaddr_d  = 1'b0;
    iram_d   = 1'b0;
    eram_d   = 1'b0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_DEC:  sp_dec_d = 1'b1;
      ST_ADDR: begin
        edr_sp_d = 1'b1;
        iaddr_d  = 1'b1;
      end
      ST_XFER: begin
        if (op_d == OP_PUSH) begin
          edr_d  = sel_d;
          iram_d = 1'b1;
        end else begin
          idr_d  = sel_d;
          eram_d = 1'b1;
        end
      end
      ST_INC:  sp_inc_d = 1'b1;
      ST_FIN:  done_d = 1'b1;
      ST_FLT: begin
        done_d  = 1'b1;
        fault_d = 1'b1;
      end
      default: begin
        busy_d = (state_d != ST_IDLE);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PUSH;
      sel_q    <= 3'b000;
      idr_q    <= 3'b000;
      edr_q    <= 3'b000;
      edr_sp_q <= 1'b0;
      sp_dec_q <= 1'b0;
      sp_inc_q <= 1'b0;
      iaddr_q  <= 1'b0;
      iram_q   <= 1'b0;
      eram_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      idr_q    <= idr_d;
      edr_q    <= edr_d;
      edr_sp_q <= edr_sp_d;
      sp_dec_q <= sp_dec_d;
      sp_inc_q <= sp_inc_d;
      iaddr_q  <= iaddr_d;
      iram_q   <= iram_d;
      eram_q   <= eram_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign idr_0  = idr_q[SEL_R0];
  assign idr_bp = idr_q[SEL_BP];
  assign idr_1  = idr_q[SEL_R1];
  assign edr_0  = edr_q[SEL_R0];
  assign edr_bp = edr_q[SEL_BP];
  assign edr_1  = edr_q[SEL_R1];
  assign edr_sp = edr_sp_q;
  assign sp_dec = sp_dec_q;
  assign sp_inc = sp_inc_q;
  assign iaddr  = iaddr_q;
  assign iram   = iram_q;
  assign eram   = eram_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign fault  = fault_q;

endmodule
`default_nettype wire
